aes_decipher_key_sched: RTL and testbench
=========================================

Name: aes_decipher_key_sched

Overview:
- Upstream key-schedule stage for the AES-128 decipher core.
- Loads a 128-bit cipher key and expands it iteratively, one round key per clock, into an 11-entry round-key store.
- Drives the decipher core's final round key (round_key_10) and the per-round inverse-order key (round_key_inv), selected by the core's round_num.
- Signals key_ready once the whole schedule is valid.

Parameters:
NUM_ROUNDS, 10, number of AES rounds; only 10 (AES-128) is supported; any other value is a configuration error.

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  reset, asynchronous, active-low
key_load  input  1  single-cycle pulse: capture key_in and start expansion
key_in  input  128  cipher key; [127:96]=w0, [95:64]=w1, [63:32]=w2, [31:0]=w3
round_num  input  4  round index from the decipher core
key_busy  output  1  expansion in progress
key_ready  output  1  all 11 round keys valid
round_key_10  output  128  round key 10 (last encryption round key)
round_key_inv  output  128  round key selected by round_num (inverse order)

Behaviour:
- Reset (async, rst_n=0): state IDLE; key_busy=0; key_ready=0; round counter=0; all 11 store entries=128'h0; round_key_10=0; round_key_inv=0.
- FSM states: IDLE, EXPAND, READY.
  - IDLE --key_load--> EXPAND.
  - EXPAND --counter reaches 10--> READY.
  - READY --key_load--> EXPAND.
  - key_load in EXPAND restarts expansion from the new key_in: rk0 overwritten, counter reset to 1, key_ready stays 0.
- On key_load (any state):
  - rk0 <= key_in; counter <= 1.
  - key_busy=1 and key_ready=0 from the next cycle.
- EXPAND, each cycle with counter=i (1..10):
  - rk[i] <= f(rk[i-1], rcon[i]); counter <= i+1.
  - f:
    - t = SubWord(RotWord(w3)) ^ {rcon,24'h0}
    - w0' = w0^t; w1' = w1^w0'; w2' = w2^w1'; w3' = w3^w2'.
  - RotWord: {b1,b2,b3,b0}.
  - SubWord: four forward S-box byte lookups, combinational.
  - rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36.
- Termination: on the cycle rk10 is written, the FSM moves to READY. key_busy=0 and key_ready=1 from the following cycle.
- Latency: key_load at edge N -> key_ready high after edge N+11 (11 cycles).
- key_ready stays high until the next key_load or reset.
- round_key_10: combinational = rk10.
- round_key_inv: combinational from round_num:
  - round_num 1..10 -> rk[10-round_num], i.e. round 1 -> rk9 ... round 10 -> rk0.
  - round_num 0 -> rk10.
  - round_num 11..15 -> rk0.
- Outputs are only meaningful while key_ready=1. During EXPAND, partially written entries are visible; no masking.
- key_load and a round_num change in the same cycle: the new load takes precedence. The stored keys are still the old ones on that cycle's outputs and change on later edges.
- Reset mid-EXPAND: immediate return to IDLE, store cleared; a subsequent key_load is required.
- key_in is sampled only on key_load and may change freely otherwise.
- No combinational path from key_in to any output.

Test Plan:
- Reset with key_load=0 -> key_busy=0, key_ready=0, round_key_10=0, round_key_inv=0; no change for 20 cycles.
- key_load with key_in=2b7e151628aed2a6abf7158809cf4f3c -> key_busy=1 for 11 cycles, then key_ready=1.
  - round_key_10=d014f9a8c9ee2589e13f0cc8b6630ca6.
  - round_num=9 -> round_key_inv=a0fafe1788542cb123a339392a6c7605.
  - round_num=10 -> round_key_inv=2b7e1516....
- key_in=000102030405060708090a0b0c0d0e0f -> round_key_10=13111d7fe3944a17f307a78b4d2b30c5.
  - Sweep round_num 0..15 -> each output matches the index mapping, including 0->rk10 and 11..15->rk0.
- Second key_load issued 5 cycles into expansion -> key_ready first rises 11 cycles after the second load with the second key's schedule; no key_ready pulse in between.
- rst_n asserted mid-EXPAND (counter=6) -> outputs 0 immediately, state IDLE.
  - key_load afterwards -> full 11-cycle expansion with correct keys.
- In READY, a new key_load -> key_ready drops the next cycle; rk10 updates to the new key's value at the end of expansion.

Source files
------------

// File: rtl/aes_decipher_key_sched.sv
// AES-128 key schedule feeding the decipher core: expands one round key per
// clock into an 11-entry store and serves the keys back in inverse order.
module aes_decipher_key_sched #(
  parameter int NUM_ROUNDS = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         key_load,
  input  logic [127:0] key_in,
  input  logic [3:0]   round_num,
  output logic         key_busy,
  output logic         key_ready,
  output logic [127:0] round_key_10,
  output logic [127:0] round_key_inv
);

  generate
    if (NUM_ROUNDS != 10) begin : g_bad_cfg
      $error("aes_decipher_key_sched supports only NUM_ROUNDS = 10");
    end
  endgenerate

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] EXPAND = 2'd1;
  localparam logic [1:0] READY  = 2'd2;

  // Forward S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] SBOX_FLAT = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [10:0] base;
    base = {~a, 3'b000};
    return SBOX_FLAT[base +: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  logic [1:0]   state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic         busy_q, busy_d;
  logic         ready_q, ready_d;
  logic [127:0] rk_q [0:10];
  logic [127:0] prev_key, nxt_key;
  logic [31:0]  rot_w, sub_w, t_w, w0n, w1n, w2n, w3n;

  always_comb begin
    prev_key = '0;
    for (int i = 1; i <= 10; i++) begin
      if (cnt_q == 4'(i)) prev_key = rk_q[i-1];
    end
    rot_w = {prev_key[23:0], prev_key[31:24]};
    sub_w = {sbox(rot_w[31:24]), sbox(rot_w[23:16]), sbox(rot_w[15:8]), sbox(rot_w[7:0])};
    t_w   = sub_w ^ {rcon(cnt_q), 24'h0};
    w0n   = prev_key[127:96] ^ t_w;
    w1n   = prev_key[95:64]  ^ w0n;
    w2n   = prev_key[63:32]  ^ w1n;
    w3n   = prev_key[31:0]   ^ w2n;
    nxt_key = {w0n, w1n, w2n, w3n};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    ready_d = ready_q;
    if (key_load) begin
      state_d = EXPAND;
      cnt_d   = 4'd1;
      busy_d  = 1'b1;
      ready_d = 1'b0;
    end else begin
      case (state_q)
        EXPAND: begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd10) state_d = READY;
        end
        READY: begin
          // Flags settle one cycle after the last key lands in the store.
          if (!ready_q) begin
            ready_d = 1'b1;
            busy_d  = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
    end
  end

  // A load wins over the expansion write scheduled for the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= 10; i++) rk_q[i] <= '0;
    end else if (key_load) begin
      rk_q[0] <= key_in;
    end else if (state_q == EXPAND) begin
      for (int i = 1; i <= 10; i++) begin
        if (cnt_q == 4'(i)) rk_q[i] <= nxt_key;
      end
    end
  end

  always_comb begin
    round_key_inv = rk_q[0];
    if (round_num == 4'd0) begin
      round_key_inv = rk_q[10];
    end else begin
      for (int i = 1; i <= 10; i++) begin
        if (round_num == 4'(i)) round_key_inv = rk_q[10-i];
      end
    end
  end

  assign round_key_10 = rk_q[10];
  assign key_busy     = busy_q;
  assign key_ready    = ready_q;

endmodule

// File: tb/tb_aes_decipher_key_sched.sv
// Bench for aes_decipher_key_sched: known-answer table, index sweep against a
// schedule expanded in the bench, restart/reset/reload sequences.
module tb_aes_decipher_key_sched;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         key_load = 1'b0;
  logic [127:0] key_in = '0;
  logic [3:0]   round_num = '0;
  logic         key_busy, key_ready;
  logic [127:0] round_key_10, round_key_inv;

  aes_decipher_key_sched #(.NUM_ROUNDS(10)) dut (
    .clk(clk), .rst_n(rst_n), .key_load(key_load), .key_in(key_in),
    .round_num(round_num), .key_busy(key_busy), .key_ready(key_ready),
    .round_key_10(round_key_10), .round_key_inv(round_key_inv)
  );

  always #5 clk = ~clk;

  typedef logic [127:0] sched_t [11];
  typedef struct {
    logic [127:0] key;
    logic [127:0] rk10;
    logic [3:0]   rn;
    logic [127:0] inv;
  } vec_t;

  int tests = 0;
  int fails = 0;
  logic [7:0]   sb [256];
  logic [127:0] exp_q [$];
  int since_load = 0;
  int busy_run = 0;
  bit ready_prev = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  // S-box from GF(2^8) inversion plus the affine map.
  task automatic build_sbox();
    for (int a = 0; a < 256; a++) begin
      logic [7:0] inv = 8'h00;
      logic [7:0] s;
      for (int b = 1; b < 256; b++) begin
        if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      end
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
              ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      sb[a] = s;
    end
  endtask

  task automatic expand(input logic [127:0] key, output sched_t rk);
    logic [7:0]  rc = 8'h01;
    logic [31:0] w0, w1, w2, w3, r, t;
    rk[0] = key;
    for (int i = 1; i <= 10; i++) begin
      {w0, w1, w2, w3} = rk[i-1];
      r = {w3[23:0], w3[31:24]};
      t = {sb[r[31:24]], sb[r[23:16]], sb[r[15:8]], sb[r[7:0]]} ^ {rc, 24'h0};
      w0 = w0 ^ t; w1 = w1 ^ w0; w2 = w2 ^ w1; w3 = w3 ^ w2;
      rk[i] = {w0, w1, w2, w3};
      rc = gmul(rc, 8'h02);
    end
  endtask

  function automatic int inv_idx(input int rn);
    if (rn == 0) return 10;
    if (rn <= 10) return 10 - rn;
    return 0;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic do_load(input logic [127:0] key);
    sched_t s;
    @(posedge clk); #1;
    key_in = key;
    key_load = 1'b1;
    if (exp_q.size() > 0) void'(exp_q.pop_back());
    expand(key, s);
    exp_q.push_back(s[10]);
    @(posedge clk); #1;
    key_load = 1'b0;
    key_in = rand128();
  endtask

  task automatic wait_ready();
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (key_ready) seen = 1'b1;
    end
    if (!seen) check("ready_timeout", 128'(key_ready), 128'(1));
  endtask

  always @(posedge clk) begin
    if (key_load) begin
      since_load = 0;
      busy_run = 0;
    end else begin
      since_load++;
    end
  end

  // Scoreboard: every rising key_ready consumes the schedule of the last load.
  always @(negedge clk) begin
    if (!rst_n) begin
      busy_run = 0;
      ready_prev = 1'b0;
    end else begin
      if (key_busy) busy_run++;
      if (key_ready && !ready_prev) begin
        check("latency", 128'(since_load), 128'(11));
        check("busy_len", 128'(busy_run), 128'(11));
        busy_run = 0;
        if (exp_q.size() == 0) check("unexpected_ready", 128'(1), 128'(0));
        else check("rk10_sb", round_key_10, exp_q.pop_front());
      end
      ready_prev = key_ready;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t   vecs [5];
    sched_t s, s_old;
    logic [127:0] last_key, k;
    bit loaded = 1'b0;

    vecs[0] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6,
                4'd9, 128'ha0fafe1788542cb123a339392a6c7605};
    vecs[1] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6,
                4'd10, 128'h2b7e151628aed2a6abf7158809cf4f3c};
    vecs[2] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h13111d7fe3944a17f307a78b4d2b30c5,
                4'd0, 128'h13111d7fe3944a17f307a78b4d2b30c5};
    vecs[3] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h13111d7fe3944a17f307a78b4d2b30c5,
                4'd10, 128'h000102030405060708090a0b0c0d0e0f};
    vecs[4] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h13111d7fe3944a17f307a78b4d2b30c5,
                4'd13, 128'h000102030405060708090a0b0c0d0e0f};

    build_sbox();
    last_key = '0;

    // Reset state, held idle for 20 cycles.
    #12 rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      round_num = 4'(i);
      @(negedge clk);
      check("rst_busy", 128'(key_busy), 128'(0));
      check("rst_ready", 128'(key_ready), 128'(0));
      check("rst_rk10", round_key_10, 128'h0);
      check("rst_inv", round_key_inv, 128'h0);
    end

    // Known-answer table.
    for (int v = 0; v < 5; v++) begin
      if (!loaded || last_key !== vecs[v].key) begin
        do_load(vecs[v].key);
        check("busy_after_load", 128'(key_busy), 128'(1));
        wait_ready();
        check("busy_when_ready", 128'(key_busy), 128'(0));
        last_key = vecs[v].key;
        loaded = 1'b1;
      end
      round_num = vecs[v].rn;
      #1;
      check("kat_rk10", round_key_10, vecs[v].rk10);
      check($sformatf("kat_inv_rn%0d", vecs[v].rn), round_key_inv, vecs[v].inv);
    end

    // Full index sweep on the second known key.
    expand(last_key, s);
    for (int rn = 0; rn < 16; rn++) begin
      round_num = 4'(rn);
      #1;
      check($sformatf("sweep_rn%0d", rn), round_key_inv, s[inv_idx(rn)]);
    end

    // Restart five cycles into an expansion.
    do_load(rand128());
    repeat (3) @(posedge clk);
    k = rand128();
    do_load(k);
    wait_ready();
    round_num = 4'd10;
    #1;
    check("restart_rk0", round_key_inv, k);

    // Reset with the counter at 6.
    do_load(rand128());
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_rk10", round_key_10, 128'h0);
    check("midrst_inv", round_key_inv, 128'h0);
    check("midrst_busy", 128'(key_busy), 128'(0));
    check("midrst_ready", 128'(key_ready), 128'(0));
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    k = rand128();
    do_load(k);
    wait_ready();
    expand(k, s_old);
    for (int rn = 0; rn < 16; rn += 3) begin
      round_num = 4'(rn);
      #1;
      check($sformatf("postrst_rn%0d", rn), round_key_inv, s_old[inv_idx(rn)]);
    end

    // Reload from READY with a simultaneous round_num change.
    k = rand128();
    expand(k, s);
    @(posedge clk); #1;
    key_in = k;
    key_load = 1'b1;
    round_num = 4'd5;
    exp_q.push_back(s[10]);
    #1;
    check("reload_old_inv", round_key_inv, s_old[5]);
    @(posedge clk); #1;
    key_load = 1'b0;
    key_in = rand128();
    @(negedge clk);
    check("reload_ready_drop", 128'(key_ready), 128'(0));
    check("reload_busy", 128'(key_busy), 128'(1));
    check("reload_rk10_old", round_key_10, s_old[10]);
    wait_ready();
    round_num = 4'd10;
    #1;
    check("reload_rk0", round_key_inv, k);
    check("reload_rk10", round_key_10, s[10]);
    repeat (3) @(negedge clk);
    check("ready_holds", 128'(key_ready), 128'(1));
    check("queue_drained", 128'(exp_q.size()), 128'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
